// File: rtl/ahb_cpu_dma_arbiter.sv
// Two-master AHB-Lite arbiter/mux sharing one slave between CPU (M0) and DMA (M1).
// Round-robin grants, burst locking, INCR length cap, split address/data owners.
module ahb_cpu_dma_arbiter #(
    parameter int MAX_BEATS = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,

    input  logic        M0_HBUSREQ,
    input  logic [31:0] M0_HADDR,
    input  logic [31:0] M0_HWDATA,
    input  logic        M0_HWRITE,
    input  logic [2:0]  M0_HBURST,
    input  logic [2:0]  M0_HSIZE,
    input  logic [1:0]  M0_HTRANS,
    output logic        M0_HGRANT,
    output logic        M0_HREADY,
    output logic        M0_HRESP,

    input  logic        M1_HBUSREQ,
    input  logic [31:0] M1_HADDR,
    input  logic [31:0] M1_HWDATA,
    input  logic        M1_HWRITE,
    input  logic [2:0]  M1_HBURST,
    input  logic [2:0]  M1_HSIZE,
    input  logic [1:0]  M1_HTRANS,
    output logic        M1_HGRANT,
    output logic        M1_HREADY,
    output logic        M1_HRESP,

    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [2:0]  HBURST,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        HMASTER
);

    localparam int CW = $clog2(MAX_BEATS + 1);

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR   = 3'd1;

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);
    localparam logic [CW:0]   CAP_LIM = (CW + 1)'(MAX_BEATS);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    owner_e        addr_own;
    owner_e        addr_own_nxt;
    owner_e        data_own;
    logic          data_valid;
    logic          last_err;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] beat_nxt;

    logic          own_req;
    logic          oth_req;
    logic [1:0]    own_trans;
    logic [2:0]    own_burst;
    logic          own_xfer;
    logic          cap_hit;
    logic          preempt;
    logic          arb_pt;
    logic          handover;
    logic          restart;
    logic [CW:0]   beat_inc;

    // Address/control from the address owner, write data from the data owner
    always_comb begin
        if (addr_own == OWN_DMA) begin
            HADDR     = M1_HADDR;
            HWRITE    = M1_HWRITE;
            HBURST    = M1_HBURST;
            HSIZE     = M1_HSIZE;
            HTRANS    = M1_HTRANS;
            own_req   = M1_HBUSREQ;
            oth_req   = M0_HBUSREQ;
        end else begin
            HADDR     = M0_HADDR;
            HWRITE    = M0_HWRITE;
            HBURST    = M0_HBURST;
            HSIZE     = M0_HSIZE;
            HTRANS    = M0_HTRANS;
            own_req   = M0_HBUSREQ;
            oth_req   = M1_HBUSREQ;
        end
    end

    assign HWDATA    = (data_own == OWN_DMA) ? M1_HWDATA : M0_HWDATA;
    assign own_trans = HTRANS;
    assign own_burst = HBURST;

    assign HMASTER   = addr_own;
    assign M0_HGRANT = (addr_own == OWN_CPU);
    assign M1_HGRANT = (addr_own == OWN_DMA);
    assign M0_HREADY = HREADY;
    assign M1_HREADY = HREADY;
    assign M0_HRESP  = HRESP & data_valid & (data_own == OWN_CPU);
    assign M1_HRESP  = HRESP & data_valid & (data_own == OWN_DMA);

    // Fairness cap: the beat now on the bus would reach MAX_BEATS
    assign beat_inc = {1'b0, beat_cnt} + (CW + 1)'(1);
    assign own_xfer = (own_trans == T_NONSEQ) || (own_trans == T_SEQ);
    assign cap_hit  = (beat_inc >= CAP_LIM);
    assign preempt  = own_xfer && (own_burst == B_INCR) && cap_hit && oth_req;

    assign arb_pt = HREADY && (
                        (own_trans == T_IDLE) ||
                        ((own_trans == T_NONSEQ) && (own_burst == B_SINGLE)) ||
                        !own_req ||
                        preempt ||
                        last_err);

    always_comb begin
        addr_own_nxt = addr_own;
        handover     = 1'b0;
        if (arb_pt && oth_req) begin
            addr_own_nxt = owner_e'(~addr_own);
            handover     = 1'b1;
        end
    end

    assign restart = handover || (own_trans == T_IDLE);

    always_comb begin
        beat_nxt = beat_cnt;
        unique case (1'b1)
            restart:
                beat_nxt = '0;
            !restart && (own_trans == T_NONSEQ):
                beat_nxt = CW'(1);
            !restart && (own_trans == T_SEQ):
                beat_nxt = (beat_cnt == CNT_MAX) ? beat_cnt : beat_inc[CW-1:0];
            default:
                beat_nxt = beat_cnt;
        endcase
    end

    // Wait states freeze everything, including the pending arbitration
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_own   <= OWN_CPU;
            data_own   <= OWN_CPU;
            data_valid <= 1'b0;
            last_err   <= 1'b0;
            beat_cnt   <= '0;
        end else if (HREADY) begin
            addr_own   <= addr_own_nxt;
            data_own   <= addr_own;
            data_valid <= own_xfer;
            last_err   <= HRESP & data_valid;
            beat_cnt   <= beat_nxt;
        end
    end

    logic unused_busy;
    assign unused_busy = (T_BUSY == 2'b01);

endmodule

// File: tb/tb_ahb_cpu_dma_arbiter.sv
// Self-checking bench for ahb_cpu_dma_arbiter: vector table, directed
// corner sequences and randomized traffic against a reference model.
module tb_ahb_cpu_dma_arbiter;

    localparam int MAXB = 4;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;
    localparam logic [2:0] SG  = 3'd0;
    localparam logic [2:0] INC = 3'd1;

    logic        hclk;
    logic        hreset;
    logic        m_req   [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic        m_write [2];
    logic [2:0]  m_burst [2];
    logic [2:0]  m_size  [2];
    logic [1:0]  m_trans [2];
    logic        hready;
    logic        hresp;

    logic        g0, g1, r0o, r1o, p0, p1;
    logic [31:0] s_addr, s_wdata;
    logic        s_write;
    logic [2:0]  s_burst, s_size;
    logic [1:0]  s_trans;
    logic        hmaster;

    int checks = 0;
    int errors = 0;

    ahb_cpu_dma_arbiter #(.MAX_BEATS(MAXB)) dut (
        .HCLK       (hclk),
        .HRESET     (hreset),
        .M0_HBUSREQ (m_req[0]),
        .M0_HADDR   (m_addr[0]),
        .M0_HWDATA  (m_wdata[0]),
        .M0_HWRITE  (m_write[0]),
        .M0_HBURST  (m_burst[0]),
        .M0_HSIZE   (m_size[0]),
        .M0_HTRANS  (m_trans[0]),
        .M0_HGRANT  (g0),
        .M0_HREADY  (r0o),
        .M0_HRESP   (p0),
        .M1_HBUSREQ (m_req[1]),
        .M1_HADDR   (m_addr[1]),
        .M1_HWDATA  (m_wdata[1]),
        .M1_HWRITE  (m_write[1]),
        .M1_HBURST  (m_burst[1]),
        .M1_HSIZE   (m_size[1]),
        .M1_HTRANS  (m_trans[1]),
        .M1_HGRANT  (g1),
        .M1_HREADY  (r1o),
        .M1_HRESP   (p1),
        .HADDR      (s_addr),
        .HWRITE     (s_write),
        .HBURST     (s_burst),
        .HSIZE      (s_size),
        .HTRANS     (s_trans),
        .HWDATA     (s_wdata),
        .HREADY     (hready),
        .HRESP      (hresp),
        .HMASTER    (hmaster)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            m_req[k]   = 1'b0;
            m_addr[k]  = 32'h0;
            m_wdata[k] = 32'h0;
            m_write[k] = 1'b0;
            m_burst[k] = SG;
            m_size[k]  = 3'd2;
            m_trans[k] = ID;
        end
        hready = 1'b1;
        hresp  = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
    endtask

    // Reference model: who owns the bus, how long it has held it, what
    // data phase is outstanding and whether the last one errored
    int md_own, md_down, md_beats;
    bit md_dval, md_lerr;

    function automatic void mdl_reset();
        md_own = 0; md_down = 0; md_beats = 0;
        md_dval = 0; md_lerr = 0;
    endfunction

    function automatic void mdl_step();
        int  o, x, nxt;
        bit  xfer, cap, may_switch;
        logic [1:0] t;
        o = md_own;
        x = 1 - md_own;
        t = m_trans[o];
        if (!hready) return;
        xfer = (t == NS) || (t == SQ);
        cap = xfer && (m_burst[o] == INC) && (md_beats + 1 >= MAXB) && m_req[x];
        may_switch = (t == ID) || (t == NS && m_burst[o] == SG)
                     || !m_req[o] || cap || md_lerr;
        nxt = (may_switch && m_req[x]) ? x : o;
        md_lerr = hresp && md_dval;
        md_dval = xfer;
        md_down = o;
        if (nxt != o || t == ID) md_beats = 0;
        else if (t == NS) md_beats = 1;
        else if (t == SQ) md_beats = (md_beats + 1 > MAXB) ? MAXB : md_beats + 1;
        md_own = nxt;
    endfunction

    task automatic chk_model();
        chk("r_hmaster", 32'(hmaster), 32'(md_own));
        chk("r_grant0", 32'(g0), 32'(md_own == 0));
        chk("r_grant1", 32'(g1), 32'(md_own == 1));
        chk("r_haddr", s_addr, m_addr[md_own]);
        chk("r_htrans", 32'(s_trans), 32'(m_trans[md_own]));
        chk("r_hwrite", 32'(s_write), 32'(m_write[md_own]));
        chk("r_hburst", 32'(s_burst), 32'(m_burst[md_own]));
        chk("r_hsize", 32'(s_size), 32'(m_size[md_own]));
        chk("r_hwdata", s_wdata, m_wdata[md_down]);
        chk("r_hresp0", 32'(p0), 32'(hresp && md_dval && md_down == 0));
        chk("r_hresp1", 32'(p1), 32'(hresp && md_dval && md_down == 1));
        chk("r_hready", 32'({r1o, r0o}), 32'({hready, hready}));
    endtask

    typedef struct {
        logic       r0, r1;
        logic [1:0] t0, t1;
        logic [2:0] b0, b1;
        logic       rdy;
        logic       own;
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, NS, ID, SG,  SG, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, ID, NS, SG,  SG, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, NS, ID, SG,  SG, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, ID, NS, SG,  SG, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, NS, ID, INC, SG, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, SQ, ID, INC, SG, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, SQ, ID, INC, SG, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, ID, ID, INC, SG, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, ID, NS, SG,  SG, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, ID, ID, SG,  SG, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b0, ID, ID, SG,  SG, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, ID, ID, SG,  SG, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b0, NS, ID, SG,  SG, 1'b1, 1'b0};

        // Reset state, with HRESP high to show no data phase is pending
        idle_all();
        hreset = 1'b1;
        hresp = 1'b1;
        m_addr[0] = 32'h1111_0000; m_addr[1] = 32'h2222_0000;
        m_wdata[0] = 32'h3333_0000; m_wdata[1] = 32'h4444_0000;
        #2;
        chk("rst_grant0", 32'(g0), 32'd1);
        chk("rst_grant1", 32'(g1), 32'd0);
        chk("rst_hmaster", 32'(hmaster), 32'd0);
        chk("rst_hresp", 32'({p1, p0}), 32'd0);
        chk("rst_haddr", s_addr, 32'h1111_0000);
        chk("rst_hwdata", s_wdata, 32'h3333_0000);
        tick();
        hreset = 1'b0;
        hresp = 1'b0;

        // Single write
        m_req[0] = 1'b1; m_trans[0] = NS; m_burst[0] = SG;
        m_write[0] = 1'b1; m_addr[0] = 32'h100; m_wdata[1] = 32'h5555_AAAA;
        #3;
        chk("sw_haddr", s_addr, 32'h100);
        chk("sw_hwrite", 32'(s_write), 32'd1);
        chk("sw_htrans", 32'(s_trans), 32'(NS));
        tick();
        m_req[0] = 1'b0; m_trans[0] = ID; m_wdata[0] = 32'hDEAD_BEEF;
        #3;
        chk("sw_hwdata", s_wdata, 32'hDEAD_BEEF);
        tick();

        // Round-robin, INCR lock, parking, wait state, grant latency
        do_reset();
        for (int i = 0; i < 13; i++) begin
            m_req[0] = tbl[i].r0; m_req[1] = tbl[i].r1;
            m_trans[0] = tbl[i].t0; m_trans[1] = tbl[i].t1;
            m_burst[0] = tbl[i].b0; m_burst[1] = tbl[i].b1;
            hready = tbl[i].rdy;
            m_addr[0] = 32'h1000 + i; m_addr[1] = 32'h2000 + i;
            #3;
            chk($sformatf("v%0d_grant0", i), 32'(g0), 32'(!tbl[i].own));
            chk($sformatf("v%0d_grant1", i), 32'(g1), 32'(tbl[i].own));
            chk($sformatf("v%0d_hmaster", i), 32'(hmaster), 32'(tbl[i].own));
            chk($sformatf("v%0d_haddr", i), s_addr, tbl[i].own ? m_addr[1] : m_addr[0]);
            chk($sformatf("v%0d_htrans", i), 32'(s_trans), 32'(tbl[i].own ? m_trans[1] : m_trans[0]));
            tick();
        end

        // Preempt after MAXB beats, handover wait states, then error release
        do_reset();
        m_req[1] = 1'b1; m_wdata[1] = 32'hBBBB_0000;
        m_req[0] = 1'b1; m_burst[0] = INC;
        for (int k = 1; k <= 4; k++) begin
            m_trans[0] = (k == 1) ? NS : SQ;
            m_addr[0] = 32'h300 + 4 * (k - 1);
            m_wdata[0] = 32'hA000_0000 + k - 1;
            #3;
            chk($sformatf("pre_b%0d_grant0", k), 32'(g0), 32'd1);
            chk($sformatf("pre_b%0d_grant1", k), 32'(g1), 32'd0);
            tick();
        end
        m_trans[0] = NS; m_addr[0] = 32'h310; m_wdata[0] = 32'hA000_0004;
        m_trans[1] = NS; m_burst[1] = INC; m_addr[1] = 32'h400;
        m_write[1] = 1'b1; hready = 1'b0;
        #3;
        chk("pre_grant0", 32'(g0), 32'd0);
        chk("pre_grant1", 32'(g1), 32'd1);
        chk("pre_hmaster", 32'(hmaster), 32'd1);
        chk("pre_haddr", s_addr, 32'h400);
        chk("pre_hwdata", s_wdata, 32'hA000_0004);
        for (int w = 0; w < 3; w++) begin
            tick();
            hready = (w == 2);
            #3;
            chk($sformatf("ws%0d_grant1", w), 32'(g1), 32'd1);
            chk($sformatf("ws%0d_haddr", w), s_addr, 32'h400);
            chk($sformatf("ws%0d_hwdata", w), s_wdata, 32'hA000_0004);
        end
        tick();
        m_trans[1] = SQ; m_addr[1] = 32'h404; m_wdata[1] = 32'hB000_0001;
        hresp = 1'b1;
        #3;
        chk("err_hresp1", 32'(p1), 32'd1);
        chk("err_hresp0", 32'(p0), 32'd0);
        chk("err_hwdata", s_wdata, 32'hB000_0001);
        tick();
        hresp = 1'b0; m_addr[1] = 32'h408;
        #3;
        chk("err_hold_grant1", 32'(g1), 32'd1);
        tick();
        #3;
        chk("err_grant0", 32'(g0), 32'd1);
        chk("err_hmaster", 32'(hmaster), 32'd0);
        chk("err_hresp1_clr", 32'(p1), 32'd0);
        tick();

        // Asynchronous reset in the middle of an M1 burst
        do_reset();
        m_req[1] = 1'b1; m_trans[1] = NS; m_burst[1] = INC; m_addr[1] = 32'h500;
        #3;
        chk("mr_grant0_c0", 32'(g0), 32'd1);
        tick();
        #3;
        chk("mr_grant1_c1", 32'(g1), 32'd1);
        chk("mr_haddr_c1", s_addr, 32'h500);
        tick();
        m_trans[1] = SQ; m_addr[1] = 32'h504; hresp = 1'b1;
        m_wdata[0] = 32'h0C0C_0C0C; m_wdata[1] = 32'h1D1D_1D1D;
        #1;
        chk("mr_hresp1_pre", 32'(p1), 32'd1);
        hreset = 1'b1;
        #1;
        chk("mr_hmaster", 32'(hmaster), 32'd0);
        chk("mr_grant0", 32'(g0), 32'd1);
        chk("mr_grant1", 32'(g1), 32'd0);
        chk("mr_hresp1", 32'(p1), 32'd0);
        tick();
        hreset = 1'b0; hresp = 1'b0; m_wdata[0] = 32'h0E0E_0E0E;
        #3;
        chk("mr_hwdata", s_wdata, 32'h0E0E_0E0E);
        tick();

        // Randomized traffic against the reference model
        do_reset();
        mdl_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 2; k++) begin
                m_req[k]   = ($urandom_range(0, 9) < 7);
                m_trans[k] = 2'($urandom_range(0, 3));
                m_burst[k] = 3'($urandom_range(0, 1));
                m_addr[k]  = $urandom;
                m_wdata[k] = $urandom;
                m_write[k] = 1'($urandom_range(0, 1));
                m_size[k]  = 3'($urandom_range(0, 2));
            end
            hready = ($urandom_range(0, 9) < 8);
            hresp  = ($urandom_range(0, 9) == 0);
            #3;
            chk_model();
            tick();
            mdl_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_cpu_dma_arbiter.md
# ahb_cpu_dma_arbiter

Two-master AHB-Lite arbiter and bus multiplexer. It shares the single AHB-Lite slave port (the CPU/DMA memory-write slave) between master 0 (CPU) and master 1 (DMA). It uses round-robin arbitration, locks the bus for the length of a burst, and caps INCR burst length for fairness. Address/control are routed from the address-phase owner and HWDATA from the data-phase owner. The slave's HREADY/HRESP are returned to the masters.

## Interface
- MAX_BEATS, 16, maximum INCR beats one master keeps the bus while the other requests (≥1)
- HCLK  in  1  bus clock; all state on rising edge
- HRESET  in  1  asynchronous, active-high reset
- M0_HBUSREQ, M1_HBUSREQ  in  1  bus request per master
- Mx_HADDR  in  32  master address (x = 0,1, likewise below)
- Mx_HWDATA  in  32  master write data
- Mx_HWRITE  in  1  master write flag
- Mx_HBURST  in  3  SINGLE=0, INCR=1
- Mx_HSIZE  in  3  transfer size
- Mx_HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- Mx_HGRANT  out  1  master owns the address phase
- Mx_HREADY  out  1  slave HREADY copy
- Mx_HRESP  out  1  OKAY=0, ERROR=1
- HADDR, HWRITE, HBURST, HSIZE, HTRANS  out  32,1,3,3,2  to slave, muxed by address owner
- HWDATA  out  32  to slave, muxed by data owner
- HREADY  in  1  slave ready
- HRESP  in  1  slave response
- HMASTER  out  1  current address-phase owner

## Operation
- Registered state:
  - addr_own: address owner, drives HMASTER and Mx_HGRANT.
  - data_own and data_valid: data owner and whether a data phase is pending.
  - last_err: registered error flag.
  - beat_cnt: width $clog2(MAX_BEATS+1), saturating at MAX_BEATS.
- Routing:
  - Slave-side address/control = addr_own master's signals, combinational.
  - HWDATA = data_own master's HWDATA.
  - Mx_HREADY = HREADY for both masters.
  - HRESP goes to the data owner when data_valid; otherwise Mx_HRESP = OKAY.
- Arbitration point: a cycle with HREADY=1 and any of:
  - owner HTRANS=IDLE
  - owner HTRANS=NONSEQ with HBURST=SINGLE
  - owner HBUSREQ=0
  - preempt: owner in INCR (NONSEQ/SEQ), beat_cnt+1 ≥ MAX_BEATS, other master requesting
  - last_err=1
- At an arbitration point:
  - If the other master requests, addr_own flips to it.
  - Else if the owner requests, addr_own is kept.
  - Else addr_own is kept (park on last owner).
- Owner HTRANS=BUSY or SEQ without preempt is never an arbitration point.
- Transfer in the arbitration cycle is always accepted and routed from the old owner. The new owner's signals appear on the slave side the next cycle, and the new owner must start with NONSEQ.
- Pipeline, updated only on HREADY=1:
  - data_own ← addr_own
  - data_valid ← (routed HTRANS ∈ {NONSEQ, SEQ})
  - last_err ← HRESP & data_valid
- Beat counter, updated on HREADY=1:
  - routed NONSEQ → beat_cnt=1
  - routed SEQ → beat_cnt+1
  - grant change or IDLE → 0
- ERROR: HRESP=1 is forwarded to the data owner. last_err forces an arbitration point on the next HREADY=1 cycle, which releases an INCR lock.
- HREADY=0: all registers hold, arbitration deferred, routing unchanged.

## Timing
- Reset (async, immediate) values:
  - addr_own=0, data_own=0, data_valid=0, beat_cnt=0, last_err=0
  - M0_HGRANT=1, M1_HGRANT=0, HMASTER=0
  - Mx_HRESP=OKAY
  - Slave-side address/control/HWDATA follow M0 inputs combinationally.
- Grant latency: 1 cycle from the arbitration point (HREADY=1 edge) to the Mx_HGRANT change.
- Idle master requesting against a parked idle owner: HBUSREQ high in cycle n → HGRANT high in cycle n+1 → its NONSEQ is accepted in n+1 at the earliest.
- Data phase lags address phase by exactly one HREADY=1 cycle. A handover cycle therefore has HADDR from the new owner and HWDATA from the old one.
- Simultaneous requests at an arbitration point go to the non-owner (round-robin). Two consecutive arbitration points with both requesting alternate masters.
- Reset mid-burst: immediate return to the reset state; the in-flight data phase is dropped (data_valid=0).

## Test plan
- **Reset:** assert HRESET mid M1 burst → within same cycle HMASTER=0, M0_HGRANT=1, M1_HGRANT=0; after release HWDATA = M0_HWDATA.
- **Single write:** M0 NONSEQ SINGLE write HADDR=0x100, M0_HWDATA=0xDEADBEEF next cycle, HREADY=1 → HADDR=0x100, HWRITE=1 in cycle 0; HWDATA=0xDEADBEEF in cycle 1.
- **Round-robin:** both HBUSREQ=1, M0 owner issuing SINGLE transfers → grant alternates M1, M0, M1 on successive arbitration points; HMASTER matches.
- **INCR lock:** M0 INCR NONSEQ + 3 SEQ (0x200..0x20C), M1 requesting from cycle 0, MAX_BEATS=16 → M1_HGRANT stays 0 until M0 drives IDLE; M1_HGRANT=1 the cycle after.
- **Preempt:** MAX_BEATS=4, M0 INCR of 10 beats, M1 requesting → after 4th beat accepted M0_HGRANT=0, M1_HGRANT=1. In that cycle HADDR is from M1 and HWDATA is beat-4 data from M0.
- **Wait states and error:** HREADY=0 for 3 cycles at handover → grant, HADDR, HWDATA frozen. Then HRESP=1 during an M1 INCR beat → M1_HRESP=1, M0_HRESP=0, and M0 granted on next HREADY=1 if requesting.
